mdu: RTL and testbench

- Multiply/divide unit in the E stage of the five-stage MIPS pipeline.
- Directly consumes the 4-bit md_sel from the instruction decoder, plus forwarded rs/rt operands.
- Holds the architectural HI/LO registers and models multi-cycle latency.
- Drives start/busy to the hazard unit and the mfhi/mflo read value to the E-stage result mux.

---
 rtl/mdu.sv | 136 +++++++++++++
 tb/tb_mdu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// E-stage multiply/divide unit holding HI/LO. A result is computed at issue, then committed N cycles later.
// The unit never stalls the pipe itself: while it is busy it ignores requests, and start/busy go to the hazard unit.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_ok;
  logic          ld_pend, commit, wr_hi, wr_lo;
  logic [31:0]   res_hi, res_lo;
  logic          res_ok;
  logic signed [63:0] prod_s;
  logic [63:0]   prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Result computed at issue; res_ok clear means divide by zero, so HI/LO are left untouched
  always_comb begin
    res_hi = 32'b0;
    res_lo = 32'b0;
    res_ok = 1'b1;
    case (md_sel)
      4'd1: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      4'd2: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      4'd3: begin
        if (b == 32'b0) begin
          res_ok = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'b0;
        end else begin
          res_lo = $signed(a) / $signed(b);
          res_hi = $signed(a) % $signed(b);
        end
      end
      4'd4: begin
        if (b == 32'b0) begin
          res_ok = 1'b0;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    ld_pend   = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: begin
        case (md_sel)
          4'd1, 4'd2, 4'd3, 4'd4: begin
            start     = 1'b1;
            ld_pend   = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = (md_sel <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          end
          4'd7:    wr_hi = 1'b1;
          4'd8:    wr_lo = 1'b1;
          default: ;
        endcase
      end
      RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= 32'b0;
      pend_lo <= 32'b0;
      pend_ok <= 1'b0;
      hi      <= 32'b0;
      lo      <= 32'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ld_pend) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_ok <= res_ok;
      end
      if (commit && pend_ok) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

  assign busy   = (state == RUN);
  assign md_out = (md_sel == 4'd5) ? hi : (md_sel == 4'd6) ? lo : 32'b0;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written corner sequences, randomized ops vs a reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_sel;
  logic [31:0] a, b;
  logic        start, busy;
  logic [31:0] hi, lo, md_out;

  int checks = 0;
  int errors = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_sel(md_sel), .a(a), .b(b),
    .start(start), .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO
  function automatic int model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                               inout logic [31:0] h, inout logic [31:0] l);
    longint sx, sy, sp;
    longint unsigned up;
    sx = $signed(x);
    sy = $signed(y);
    case (s)
      4'd1: begin sp = sx * sy; h = sp[63:32]; l = sp[31:0]; return 5; end
      4'd2: begin up = 64'(x) * 64'(y); h = up[63:32]; l = up[31:0]; return 5; end
      4'd3: begin
        if (y != 0) begin sp = sx / sy; l = sp[31:0]; sp = sx % sy; h = sp[31:0]; end
        return 10;
      end
      4'd4: begin
        if (y != 0) begin l = x / y; h = x % y; end
        return 10;
      end
      4'd7: h = x;
      4'd8: l = x;
      default: ;
    endcase
    return 0;
  endfunction

  initial begin
    int n;
    logic [3:0]  s;
    logic [31:0] ra, rb, m_hi, m_lo;
    int exp_n;

    vecs[0] = '{4'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{4'd7, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFD, 0};
    vecs[4] = '{4'd8, 32'h9ABC_DEF0, 32'd0,         32'h1234_5678, 32'h9ABC_DEF0, 0};
    vecs[5] = '{4'd4, 32'h0000_0055, 32'd0,         32'h1234_5678, 32'h9ABC_DEF0, 10};
    vecs[6] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[7] = '{4'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
    vecs[8] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};

    reset = 1'b1; md_sel = 4'd0; a = 32'b0; b = 32'b0;
    #2;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    #6 reset = 1'b0;
    step();

    // Directed table; each row issues in the first idle cycle after the previous one
    for (int i = 0; i < 9; i++) begin
      md_sel = vecs[i].sel; a = vecs[i].va; b = vecs[i].vb;
      #1;
      check($sformatf("vec%0d_start", i), {31'b0, start},
            {31'b0, (vecs[i].sel >= 4'd1 && vecs[i].sel <= 4'd4)});
      @(posedge clk); #1;
      md_sel = 4'd0;
      wait_idle(n);
      check($sformatf("vec%0d_cycles", i), n, vecs[i].cycles);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    md_sel = 4'd5; #1;
    check("mfhi", md_out, 32'h0000_0001);
    md_sel = 4'd6; #1;
    check("mflo", md_out, 32'hFFFF_FFFD);
    md_sel = 4'd11; #1;
    check("sel11_out", md_out, 32'h0);
    check("sel11_start", {31'b0, start}, 32'h0);
    step();
    check("sel11_busy", {31'b0, busy}, 32'h0);

    // Requests arriving while busy are dropped
    md_sel = 4'd1; a = 32'd3; b = 32'd4;
    step();
    md_sel = 4'd7; a = 32'hDEAD_BEEF; #1;
    check("ign_mthi_start", {31'b0, start}, 32'h0);
    step();
    md_sel = 4'd3; a = 32'd9; b = 32'd2; #1;
    check("ign_div_start", {31'b0, start}, 32'h0);
    md_sel = 4'd5; #1;
    check("mfhi_busy", md_out, 32'h0000_0001);
    step();
    md_sel = 4'd0;
    wait_idle(n);
    check("ign_cycles", n + 2, 5);
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'd12);

    // Asynchronous reset in the third busy cycle of a div
    md_sel = 4'd3; a = 32'd100; b = 32'd3;
    step();
    md_sel = 4'd0;
    step(); step();
    check("mid_busy_before", {31'b0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    #3 reset = 1'b0;
    step();
    md_sel = 4'd1; a = 32'd6; b = 32'd7;
    step();
    md_sel = 4'd0;
    wait_idle(n);
    check("post_rst_cycles", n, 5);
    check("post_rst_hi", hi, 32'h0);
    check("post_rst_lo", lo, 32'd42);

    // Randomized ops against the model, with junk requests driven during busy windows
    m_hi = hi; m_lo = lo;
    for (int i = 0; i < 300; i++) begin
      s  = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      md_sel = s; a = ra; b = rb;
      #1;
      check("rnd_start", {31'b0, start}, {31'b0, (s >= 4'd1 && s <= 4'd4)});
      check("rnd_md_out", md_out, (s == 4'd5) ? m_hi : (s == 4'd6) ? m_lo : 32'h0);
      exp_n = model(s, ra, rb, m_hi, m_lo);
      @(posedge clk); #1;
      n = 0;
      while (busy && n < 100) begin
        md_sel = 4'($urandom_range(1, 15)); a = $urandom; b = $urandom;
        n++;
        @(posedge clk); #1;
      end
      md_sel = 4'd0;
      check("rnd_cycles", n, exp_n);
      check("rnd_hi", hi, m_hi);
      check("rnd_lo", lo, m_lo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
